bp_be_instr_predecode: RTL and testbench

- Sits between the fetch queue and the BE issue/decode stage.
- Accepts raw 32-bit RV64I instructions with their PC over a valid/ready handshake.
- Classifies each instruction's encoding format from its opcode, extracts register and funct fields, generates the sign-extended 64-bit immediate and flags illegal encodings.
- Buffers decoded records in a 2-entry queue and presents them to issue over valid/ready.

---
 rtl/bp_be_predecode_pkg.sv | 58 +++++
 rtl/bp_be_imm_gen.sv | 43 ++++
 rtl/bp_be_instr_predecode.sv | 131 +++++++++++++
 tb/tb_bp_be_instr_predecode.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_predecode_pkg.sv
// Shared types for the BE instruction predecoder: RV64I opcodes, the format
// enum and the decoded-record layout that is carried into the issue queue.
package bp_be_predecode_pkg;

  localparam logic [6:0] RV64_LOAD_OP      = 7'b0000011;
  localparam logic [6:0] RV64_MISC_MEM_OP  = 7'b0001111;
  localparam logic [6:0] RV64_OP_IMM_OP    = 7'b0010011;
  localparam logic [6:0] RV64_AUIPC_OP     = 7'b0010111;
  localparam logic [6:0] RV64_OP_IMM_32_OP = 7'b0011011;
  localparam logic [6:0] RV64_STORE_OP     = 7'b0100011;
  localparam logic [6:0] RV64_OP_OP        = 7'b0110011;
  localparam logic [6:0] RV64_LUI_OP       = 7'b0110111;
  localparam logic [6:0] RV64_OP_32_OP     = 7'b0111011;
  localparam logic [6:0] RV64_BRANCH_OP    = 7'b1100011;
  localparam logic [6:0] RV64_JALR_OP      = 7'b1100111;
  localparam logic [6:0] RV64_JAL_OP       = 7'b1101111;
  localparam logic [6:0] RV64_SYSTEM_OP    = 7'b1110011;

  localparam int vaddr_width_gp = 39;

  typedef enum logic [2:0] {
    e_fmt_r       = 3'd0,
    e_fmt_i       = 3'd1,
    e_fmt_s       = 3'd2,
    e_fmt_b       = 3'd3,
    e_fmt_u       = 3'd4,
    e_fmt_j       = 3'd5,
    e_fmt_illegal = 3'd6
  } bp_be_fmt_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv64_instr_s;

  typedef struct packed {
    logic [vaddr_width_gp-1:0] pc;
    bp_be_fmt_e                fmt;
    logic [6:0]                opcode;
    logic [4:0]                rd;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [63:0]               imm;
    logic                      rs1_v;
    logic                      rs2_v;
    logic                      rd_v;
    logic                      illegal;
  } bp_be_predecode_s;

  localparam int bp_be_predecode_width_lp = $bits(bp_be_predecode_s);

endpackage

// File: rtl/bp_be_imm_gen.sv
// Combinational format classifier and sign-extended 64-bit immediate builder
// for one raw RV64I instruction word.
module bp_be_imm_gen
  import bp_be_predecode_pkg::*;
(
  input  logic [31:0] instr_i,
  output bp_be_fmt_e  fmt_o,
  output logic [63:0] imm_o
);

  bp_be_fmt_e fmt;

  always_comb begin
    fmt = e_fmt_illegal;
    // The low two opcode bits must be 2'b11, so matching the full 7 bits also
    // rejects compressed-style encodings.
    case (instr_i[6:0])
      RV64_LOAD_OP, RV64_OP_IMM_OP, RV64_OP_IMM_32_OP,
      RV64_JALR_OP, RV64_SYSTEM_OP, RV64_MISC_MEM_OP: fmt = e_fmt_i;
      RV64_STORE_OP:                                  fmt = e_fmt_s;
      RV64_OP_OP, RV64_OP_32_OP:                      fmt = e_fmt_r;
      RV64_LUI_OP, RV64_AUIPC_OP:                     fmt = e_fmt_u;
      RV64_BRANCH_OP:                                 fmt = e_fmt_b;
      RV64_JAL_OP:                                    fmt = e_fmt_j;
      default:                                        fmt = e_fmt_illegal;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (fmt)
      e_fmt_i: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
      e_fmt_s: imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      e_fmt_b: imm_o = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      e_fmt_u: imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
      e_fmt_j: imm_o = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

  assign fmt_o = fmt;

endmodule

// File: rtl/bp_be_instr_predecode.sv
// Predecodes raw RV64I words on the input side and buffers the decoded records
// in a small queue for issue. Define BP_BE_PREDECODE_STATS_EN for per-class counters.
module bp_be_instr_predecode
  import bp_be_predecode_pkg::*;
#(
  parameter int vaddr_width_p = vaddr_width_gp,
  parameter int els_p         = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                flush_i,
  input  logic [31:0]                         instr_i,
  input  logic [vaddr_width_p-1:0]            pc_i,
  input  logic                                v_i,
  output logic                                ready_o,
  output logic [bp_be_predecode_width_lp-1:0] decode_o,
  output logic                                v_o,
  input  logic                                yumi_i
`ifdef BP_BE_PREDECODE_STATS_EN
  ,
  output logic [4*32-1:0]                     stat_o
`endif
);

  localparam int ptr_w_lp = $clog2(els_p);
  typedef logic [ptr_w_lp:0] ptr_t;

  rv64_instr_s      instr_li;
  bp_be_fmt_e       fmt_li;
  logic [63:0]      imm_li;
  bp_be_predecode_s rec_li;

  assign instr_li = instr_i;

  bp_be_imm_gen imm_gen (
    .instr_i (instr_i),
    .fmt_o   (fmt_li),
    .imm_o   (imm_li)
  );

  always_comb begin
    rec_li         = '0;
    rec_li.pc      = vaddr_width_gp'(pc_i);
    rec_li.fmt     = fmt_li;
    rec_li.opcode  = instr_li.opcode;
    rec_li.rd      = instr_li.rd;
    rec_li.rs1     = instr_li.rs1;
    rec_li.rs2     = instr_li.rs2;
    rec_li.funct3  = instr_li.funct3;
    rec_li.funct7  = instr_li.funct7;
    rec_li.imm     = imm_li;
    rec_li.illegal = (fmt_li == e_fmt_illegal);
    rec_li.rs1_v   = (fmt_li == e_fmt_r) || (fmt_li == e_fmt_i)
                  || (fmt_li == e_fmt_s) || (fmt_li == e_fmt_b);
    rec_li.rs2_v   = (fmt_li == e_fmt_r) || (fmt_li == e_fmt_s) || (fmt_li == e_fmt_b);
    rec_li.rd_v    = ((fmt_li == e_fmt_r) || (fmt_li == e_fmt_i)
                  || (fmt_li == e_fmt_u) || (fmt_li == e_fmt_j)) && (instr_li.rd != 5'd0);
  end

  ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
  bp_be_predecode_s mem_q [els_p];
  bp_be_predecode_s mem_d [els_p];
  logic             full, empty, enq, deq;

  // The extra MSB on each pointer separates full (MSBs differ) from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
              && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);

  assign ready_o  = ~full & ~reset_i;
  assign v_o      = ~empty;
  assign enq      = v_i & ready_o & ~flush_i;
  assign deq      = yumi_i & ~empty & ~flush_i;
  assign decode_o = mem_q[rptr_q[ptr_w_lp-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + ptr_t'(1);
      if (deq) rptr_d = rptr_q + ptr_t'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (enq) mem_d[wptr_q[ptr_w_lp-1:0]] = rec_li;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Queue storage holds data only and is never reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef BP_BE_PREDECODE_STATS_EN
  logic [3:0][31:0] stat_q, stat_d;
  logic [1:0]       cls;

  always_comb begin
    case (fmt_li)
      e_fmt_r, e_fmt_i: cls = 2'd0;
      e_fmt_s, e_fmt_b: cls = 2'd1;
      e_fmt_u, e_fmt_j: cls = 2'd2;
      default:          cls = 2'd3;
    endcase
    stat_d = stat_q;
    if (enq && (stat_q[cls] != 32'hFFFF_FFFF)) stat_d[cls] = stat_q[cls] + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) stat_q <= '0;
    else         stat_q <= stat_d;
  end

  assign stat_o = stat_q;
`endif

endmodule

// File: tb/tb_bp_be_instr_predecode.sv
// Bench for bp_be_instr_predecode: directed instruction vectors checked against
// a spec-level queue/decode model every cycle, plus literal field checks.
module tb_bp_be_instr_predecode;
  import bp_be_predecode_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, flush_i, v_i, yumi_i;
  logic [31:0] instr_i;
  logic [38:0] pc_i;
  logic        ready_o, v_o;
  logic [bp_be_predecode_width_lp-1:0] decode_o;
`ifdef BP_BE_PREDECODE_STATS_EN
  logic [127:0] stat_o;
`endif

  bp_be_instr_predecode #(.vaddr_width_p(39), .els_p(DEPTH)) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .flush_i  (flush_i),
    .instr_i  (instr_i),
    .pc_i     (pc_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .decode_o (decode_o),
    .v_o      (v_o),
    .yumi_i   (yumi_i)
`ifdef BP_BE_PREDECODE_STATS_EN
    ,
    .stat_o   (stat_o)
`endif
  );

  bp_be_predecode_s d;
  assign d = decode_o;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Decoded record derived directly from the ISA field definitions.
  function automatic bp_be_predecode_s model(input logic [31:0] w, input logic [38:0] pc);
    bp_be_predecode_s r;
    longint sw;
    r = '0;
    sw = longint'($signed(w));
    r.pc = pc; r.opcode = w[6:0]; r.rd = w[11:7]; r.rs1 = w[19:15];
    r.rs2 = w[24:20]; r.funct3 = w[14:12]; r.funct7 = w[31:25];
    case (w[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F: r.fmt = e_fmt_i;
      7'h23:        r.fmt = e_fmt_s;
      7'h33, 7'h3B: r.fmt = e_fmt_r;
      7'h37, 7'h17: r.fmt = e_fmt_u;
      7'h63:        r.fmt = e_fmt_b;
      7'h6F:        r.fmt = e_fmt_j;
      default:      r.fmt = e_fmt_illegal;
    endcase
    r.illegal = (r.fmt == e_fmt_illegal);
    case (r.fmt)
      e_fmt_i: r.imm = sw >>> 20;
      e_fmt_s: r.imm = ((sw >>> 25) << 5) | longint'(w[11:7]);
      e_fmt_b: r.imm = ((sw >>> 31) << 12) | (longint'(w[7]) << 11)
                     | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      e_fmt_u: r.imm = (sw >>> 12) << 12;
      e_fmt_j: r.imm = ((sw >>> 31) << 20) | (longint'(w[19:12]) << 12)
                     | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      default: r.imm = '0;
    endcase
    r.rs1_v = r.fmt inside {e_fmt_r, e_fmt_i, e_fmt_s, e_fmt_b};
    r.rs2_v = r.fmt inside {e_fmt_r, e_fmt_s, e_fmt_b};
    r.rd_v  = (r.fmt inside {e_fmt_r, e_fmt_i, e_fmt_u, e_fmt_j}) && (w[11:7] != 5'd0);
    return r;
  endfunction

  function automatic int cls_of(input bp_be_fmt_e f);
    if (f inside {e_fmt_r, e_fmt_i}) return 0;
    if (f inside {e_fmt_s, e_fmt_b}) return 1;
    if (f inside {e_fmt_u, e_fmt_j}) return 2;
    return 3;
  endfunction

  bp_be_predecode_s mq[$];
  logic [31:0]      mstat[4];

  // Model state update on the same edge the DUT samples its inputs.
  always @(posedge clk) begin : model_upd
    bit e, q;
    bp_be_predecode_s r;
    if (reset_i) begin
      mq.delete();
      for (int k = 0; k < 4; k++) mstat[k] = 32'd0;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      e = v_i && (mq.size() < DEPTH);
      q = yumi_i && (mq.size() > 0);
      if (q) void'(mq.pop_front());
      if (e) begin
        r = model(instr_i, pc_i);
        mq.push_back(r);
        if (mstat[cls_of(r.fmt)] != 32'hFFFF_FFFF) mstat[cls_of(r.fmt)]++;
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("v_o", 160'(v_o), 160'(mq.size() != 0));
    chk("ready_o", 160'(ready_o), 160'(!reset_i && (mq.size() < DEPTH)));
    if (v_o && mq.size() != 0) chk("decode_o", 160'(decode_o), 160'(mq[0]));
`ifdef BP_BE_PREDECODE_STATS_EN
    if (!reset_i) chk("stat_o", 160'(stat_o), 160'({mstat[3], mstat[2], mstat[1], mstat[0]}));
`endif
  end

  task automatic send(input logic [31:0] w, input logic [38:0] pc);
    instr_i = w; pc_i = pc; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  task automatic pop();
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
  endtask

  logic [31:0] mix [12] = '{32'h002081B3, 32'h00C000EF, 32'h00008067, 32'h00001297,
                            32'h003100BB, 32'h00000001, 32'h00000013, 32'h0000000F,
                            32'h00000073, 32'hFE000EE3, 32'h0FF0A003, 32'h12345037};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : drive
    bp_be_predecode_s m;
    reset_i = 1'b1; flush_i = 1'b0; v_i = 1'b1; yumi_i = 1'b0;
    instr_i = 32'hFFF10093; pc_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 160'(ready_o), 160'(0));
    reset_i = 1'b0; v_i = 1'b0;
    chk("reset_v", 160'(v_o), 160'(0));

    // Pin the model on hand-decoded words.
    m = model(32'h00C000EF, 39'h0);
    chk("model_jal_imm", 160'(m.imm), 160'(64'd12));
    m = model(32'h00001297, 39'h0);
    chk("model_auipc_imm", 160'(m.imm), 160'(64'h1000));
    m = model(32'h00008067, 39'h0);
    chk("model_jalr_rdv", 160'({m.fmt, m.rd_v}), 160'({e_fmt_i, 1'b0}));

    // ADDI x1,x2,-1
    send(32'hFFF10093, 39'h8000_0000);
    chk("addi_v", 160'(v_o), 160'(1));
    chk("addi_fmt", 160'(d.fmt), 160'(e_fmt_i));
    chk("addi_regs", 160'({d.rd, d.rs1}), 160'({5'd1, 5'd2}));
    chk("addi_imm", 160'(d.imm), 160'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("addi_vbits", 160'({d.rd_v, d.rs2_v}), 160'(2'b10));
    chk("addi_pc", 160'(d.pc), 160'(39'h8000_0000));
    pop();

    // SW then LUI, queued back to back
    send(32'h00532423, 39'h8000_0004);
    send(32'h123451B7, 39'h8000_0008);
    chk("sw_fmt", 160'(d.fmt), 160'(e_fmt_s));
    chk("sw_regs", 160'({d.rs1, d.rs2}), 160'({5'd6, 5'd5}));
    chk("sw_imm", 160'(d.imm), 160'(64'h8));
    chk("sw_rdv", 160'(d.rd_v), 160'(0));
    pop();
    chk("lui_fmt", 160'(d.fmt), 160'(e_fmt_u));
    chk("lui_imm", 160'(d.imm), 160'(64'h0000_0000_1234_5000));
    pop();

    // BEQ x0,x0,-4 then all-zero word
    send(32'hFE000EE3, 39'h100);
    chk("beq_fmt", 160'(d.fmt), 160'(e_fmt_b));
    chk("beq_imm", 160'(d.imm), 160'(64'hFFFF_FFFF_FFFF_FFFC));
    pop();
    send(32'h0000_0000, 39'h104);
    chk("zero_illegal", 160'({d.illegal, d.fmt}), 160'({1'b1, e_fmt_illegal}));
    chk("zero_imm", 160'(d.imm), 160'(64'h0));
    chk("zero_vbits", 160'({d.rs1_v, d.rs2_v, d.rd_v}), 160'(3'b000));
    pop();

    // Streaming mix with concurrent enqueue/dequeue
    for (int i = 0; i < 12; i++) begin
      instr_i = mix[i]; pc_i = 39'(32'h200 + 4 * i); v_i = 1'b1; yumi_i = v_o;
      @(posedge clk); #1;
    end
    v_i = 1'b0;
    repeat (3) begin yumi_i = v_o; @(posedge clk); #1; end
    yumi_i = 1'b0;

    // Backpressure: three offered with no consumer
    instr_i = 32'h00100093; pc_i = 39'h300; v_i = 1'b1;
    @(posedge clk); #1;
    instr_i = 32'h00200113; pc_i = 39'h304;
    @(posedge clk); #1;
    instr_i = 32'h00300193; pc_i = 39'h308;
    chk("bp_full_ready", 160'(ready_o), 160'(0));
    yumi_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_deq", 160'(ready_o), 160'(1));
    chk("bp_order", 160'(d.pc), 160'(39'h304));
    @(posedge clk); #1;
    v_i = 1'b0;
    repeat (3) begin yumi_i = v_o; @(posedge clk); #1; end
    yumi_i = 1'b0;

    // Flush a full queue while an instruction is offered
    send(32'h00400213, 39'h400);
    send(32'h00500293, 39'h404);
    instr_i = 32'h00600313; pc_i = 39'h408; v_i = 1'b1; flush_i = 1'b1; yumi_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    chk("flush_v", 160'(v_o), 160'(0));
    chk("flush_ready", 160'(ready_o), 160'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("flush_dropped", 160'(v_o), 160'(0));

    // Class counters: 5 I-type and 1 illegal after a fresh reset
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      instr_i = (i == 5) ? 32'h0000_0002 : 32'h00A00513 + 32'(i << 20);
      pc_i = 39'(32'h500 + 4 * i); v_i = 1'b1; yumi_i = v_o;
      @(posedge clk); #1;
    end
    v_i = 1'b0; yumi_i = v_o;
    @(posedge clk); #1;
    flush_i = 1'b1; yumi_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
`ifdef BP_BE_PREDECODE_STATS_EN
    chk("stat_ri", 160'(stat_o[31:0]), 160'(32'd5));
    chk("stat_illegal", 160'(stat_o[127:96]), 160'(32'd1));
    chk("stat_sb_uj", 160'(stat_o[95:32]), 160'(64'd0));
`endif
    chk("final_empty", 160'(v_o), 160'(0));

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
